// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : shared constants and types for the PS/2 scan-code sequencer
// Revision: 1.0
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } seq_state_t;

    // 10-bit key event; 'brk' carries the break (release) flag.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// ps2_event_fifo : first-word fall-through FIFO for decoded key events
// Revision: 1.0
// ============================================================================
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  ps2_event_t push_data,
    input  logic       pop,
    output ps2_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ps2_event_t      mem_q [DEPTH];
    ps2_event_t      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head is forced to zero when empty so stale entries never show.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ps2_scan_sequencer.sv
`default_nettype none
// ============================================================================
// ps2_scan_sequencer : folds E0/F0 prefixes into key events, watchdogs stalls
// Revision: 1.0
// ============================================================================
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_dten,
    input  logic [7:0] rx_data,
    output logic       rx_clear,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    input  logic       ev_ready,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             rx_clear_q, rx_clear_d;
    logic             overflow_q, overflow_d;
    logic             wd_expire;
    logic             is_err;
    logic             is_prefix;
    logic             push;
    ps2_event_t       push_ev;
    ps2_event_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign is_err    = (rx_data == PS2_ERR0) || (rx_data == PS2_ERR1);
    assign is_prefix = (rx_data == PS2_EXT) || (rx_data == PS2_BRK);
    // A strobe in the expiry cycle takes precedence over the timeout.
    assign wd_expire = (state_q != ST_IDLE) && (wd_cnt_q == WD_LAST) && !rx_dten;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wd_cnt_q   <= '0;
            rx_clear_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_cnt_q   <= wd_cnt_d;
            rx_clear_q <= rx_clear_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (rx_dten) begin
            if (is_err) begin
                state_d = ST_IDLE;
            end else if (rx_data == PS2_EXT) begin
                case (state_q)
                    ST_IDLE, ST_EXT: state_d = ST_EXT;
                    default:         state_d = ST_IDLE;
                endcase
            end else if (rx_data == PS2_BRK) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                state_d = ST_IDLE;
            end
        end else if (wd_expire) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs: event push, watchdog, receiver clear, overflow flag
    always_comb begin
        push         = rx_dten && !is_err && !is_prefix;
        push_ev.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        push_ev.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        push_ev.code = rx_data;

        if (rx_dten || (state_q == ST_IDLE) || wd_expire) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        rx_clear_d = wd_expire;

        overflow_d = ovf_clr ? 1'b0 : overflow_q;
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    assign pop = ev_ready && !fifo_empty;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_ev),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;
    assign rx_clear = rx_clear_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ps2_scan_sequencer : directed self-checking bench for the sequencer
// Revision: 1.0
// ============================================================================
module tb_ps2_scan_sequencer;

    localparam int TMO = 50000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_dten = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_clear;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_ready = 1'b0;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    ps2_scan_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_dten  (rx_dten),
        .rx_data  (rx_data),
        .rx_clear (rx_clear),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_break (ev_break),
        .ev_ready (ev_ready),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Stimulus changes and sampling both happen on the falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dten = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_dten = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ev_valid, rx_clear, overflow, ev_ext, ev_break, ev_code} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b clr=%b ovf=%b ext=%b brk=%b code=%h, expected all 0",
                     ev_valid, rx_clear, overflow, ev_ext, ev_break, ev_code);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_make();
        send_byte(8'h1C);
        tests_run++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
            tests_failed++;
            $display("FAIL single_make: got v=%b ext=%b brk=%b code=%h, expected v=1 ext=0 brk=0 code=1c",
                     ev_valid, ev_ext, ev_break, ev_code);
        end
        pop_one();
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pop: got ev_valid=%b, expected 0", ev_valid);
        end
    endtask

    task automatic test_ext_break_hold();
        int unstable;
        ev_ready = 1'b0;
        send_byte(8'hE0);
        send_byte(8'hF0);
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prefix_no_event: got ev_valid=%b, expected 0", ev_valid);
        end
        send_byte(8'h75);
        tests_run++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b1, 1'b1, 8'h75}) begin
            tests_failed++;
            $display("FAIL ext_break_event: got v=%b ext=%b brk=%b code=%h, expected v=1 ext=1 brk=1 code=75",
                     ev_valid, ev_ext, ev_break, ev_code);
        end
        unstable = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b1, 1'b1, 8'h75}) unstable++;
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("FAIL ext_break_hold: got %0d unstable cycles, expected 0", unstable);
        end
        pop_one();
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ext_break_single: got ev_valid=%b after pop, expected 0", ev_valid);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        int first_k;
        send_byte(8'hE0);
        pulses  = (rx_clear === 1'b1) ? 1 : 0;
        first_k = (rx_clear === 1'b1) ? 0 : -1;
        for (int k = 1; k <= TMO + 5; k++) begin
            @(negedge clk);
            if (rx_clear === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL timeout_pulse_count: got %0d, expected 1", pulses);
        end
        tests_run++;
        if (first_k != TMO) begin
            tests_failed++;
            $display("FAIL timeout_pulse_cycle: got %0d, expected %0d", first_k, TMO);
        end
        send_byte(8'h1C);
        tests_run++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
            tests_failed++;
            $display("FAIL timeout_then_make: got v=%b ext=%b brk=%b code=%h, expected v=1 ext=0 brk=0 code=1c",
                     ev_valid, ev_ext, ev_break, ev_code);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_codes [4];
        exp_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D};
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(exp_codes[i]);
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_not_yet: got overflow=%b with 4 queued, expected 0", overflow);
        end
        send_byte(8'h2C);
        tests_run++;
        if (overflow !== 1'b1 || ev_code !== 8'h15) begin
            tests_failed++;
            $display("FAIL ovf_set: got overflow=%b head=%h, expected overflow=1 head=15", overflow, ev_code);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (ev_valid !== 1'b1 || ev_code !== exp_codes[i]) begin
                tests_failed++;
                $display("FAIL ovf_drain_%0d: got v=%b code=%h, expected v=1 code=%h",
                         i, ev_valid, ev_code, exp_codes[i]);
            end
            pop_one();
        end
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_drained_empty: got ev_valid=%b, expected 0", ev_valid);
        end
        clear_ovf();
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: got overflow=%b, expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_codes [4];
        exp_codes = '{8'h1D, 8'h24, 8'h2D, 8'h34};
        ev_ready = 1'b0;
        send_byte(8'h15);
        send_byte(8'h1D);
        send_byte(8'h24);
        send_byte(8'h2D);
        @(negedge clk);
        rx_dten  = 1'b1;
        rx_data  = 8'h34;
        ev_ready = 1'b1;
        @(negedge clk);
        rx_dten  = 1'b0;
        ev_ready = 1'b0;
        tests_run++;
        if (overflow !== 1'b0 || ev_code !== 8'h1D) begin
            tests_failed++;
            $display("FAIL full_push_pop: got overflow=%b head=%h, expected overflow=0 head=1d", overflow, ev_code);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (ev_valid !== 1'b1 || ev_code !== exp_codes[i]) begin
                tests_failed++;
                $display("FAIL full_drain_%0d: got v=%b code=%h, expected v=1 code=%h",
                         i, ev_valid, ev_code, exp_codes[i]);
            end
            pop_one();
        end
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drained_empty: got ev_valid=%b, expected 0", ev_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rx_dten = 1'b1;
        rx_data = 8'hE0;
        @(negedge clk);
        rx_data = 8'h74;
        @(negedge clk);
        rx_dten = 1'b0;
        tests_run++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b1, 1'b0, 8'h74}) begin
            tests_failed++;
            $display("FAIL back_to_back: got v=%b ext=%b brk=%b code=%h, expected v=1 ext=1 brk=0 code=74",
                     ev_valid, ev_ext, ev_break, ev_code);
        end
        pop_one();
    endtask

    task automatic test_error_and_reset();
        send_byte(8'hF0);
        send_byte(8'hFF);
        tests_run++;
        if (ev_valid !== 1'b0 || rx_clear !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_byte: got v=%b clr=%b, expected v=0 clr=0", ev_valid, rx_clear);
        end
        send_byte(8'h1C);
        tests_run++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
            tests_failed++;
            $display("FAIL error_then_make: got v=%b ext=%b brk=%b code=%h, expected v=1 ext=0 brk=0 code=1c",
                     ev_valid, ev_ext, ev_break, ev_code);
        end
        send_byte(8'hE0);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (ev_valid !== 1'b0 || rx_clear !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b clr=%b, expected v=0 clr=0", ev_valid, rx_clear);
        end
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h1C);
        tests_run++;
        if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
            tests_failed++;
            $display("FAIL reset_then_make: got v=%b ext=%b brk=%b code=%h, expected v=1 ext=0 brk=0 code=1c",
                     ev_valid, ev_ext, ev_break, ev_code);
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_ext_break_hold();
        test_back_to_back();
        test_timeout();
        test_overflow();
        test_full_push_pop();
        test_error_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
